// File: rtl/pdm_filt_pkg.sv
// Shared constants for the PDM decimation chain: CIC geometry, FIR taps and PDM coding.
package pdm_filt_pkg;

  localparam int unsigned CIC_R     = 64;
  localparam int unsigned CIC_N     = 4;
  localparam int unsigned CIC_W     = 2 + CIC_N * $clog2(CIC_R);
  localparam int unsigned PCM_W     = 16;

  localparam int unsigned FIR_TAPS  = 7;
  localparam int unsigned FIR_SHIFT = 5;
  // sum of |h| is 80, so 8 guard bits above the sample width cannot overflow
  localparam int unsigned FIR_GUARD = 8;
  localparam logic signed [7:0] FIR_H [FIR_TAPS] = '{
    -8'sd2, 8'sd4, -8'sd10, 8'sd48, -8'sd10, 8'sd4, -8'sd2
  };

  typedef enum logic [1:0] {
    PDM_ZERO = 2'b00,
    PDM_POS  = 2'b01,
    PDM_RSVD = 2'b10,
    PDM_NEG  = 2'b11
  } pdm_code_e;

  function automatic logic signed [1:0] pdm_decode(input logic [1:0] code);
    logic signed [1:0] val;
    case (pdm_code_e'(code))
      PDM_POS: val = 2'sb01;
      PDM_NEG: val = 2'sb11;
      default: val = 2'sb00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/clk_strobe_div.sv
// Free-running divider producing a one-clock enable pulse every DIV clocks.
module clk_strobe_div #(
  parameter int unsigned DIV = 50
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic ce_o
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             ce_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else if (cnt_q == CNT_W'(DIV - 1)) begin
      cnt_q <= '0;
      ce_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      ce_q  <= 1'b0;
    end
  end

  assign ce_o = ce_q;

endmodule

// File: rtl/pdm_cic_fir_decimator.sv
// PDM-to-PCM converter: N-stage CIC decimator followed by a 7-tap inverse-sinc FIR.
// Everything runs on clk; the PDM sample rate is an internal clock enable.
module pdm_cic_fir_decimator
  import pdm_filt_pkg::*;
#(
  parameter int unsigned DIV   = 50,
  parameter int unsigned R     = CIC_R,
  parameter int unsigned N_STG = CIC_N,
  parameter int unsigned OUT_W = PCM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       pdm_in,
  output logic [OUT_W-1:0] cic_data,
  output logic             cic_valid,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid
);

  localparam int unsigned CW    = 2 + N_STG * $clog2(R);
  localparam int unsigned DW    = $clog2(R);
  localparam int unsigned ACC_W = OUT_W + FIR_GUARD;

  logic ce;
  logic accept;

  clk_strobe_div #(.DIV(DIV)) u_strobe (
    .clk_i (clk),
    .rst_i (reset),
    .ce_o  (ce)
  );

  assign accept = ce & in_valid;

  logic signed [1:0] pdm_val;
  logic [CW-1:0]     pdm_ext;

  assign pdm_val = pdm_decode(pdm_in);
  assign pdm_ext = {{(CW-2){pdm_val[1]}}, pdm_val};

  // Integrators: full chain settles within one accepted sample; wraps mod 2^CW.
  logic [CW-1:0] integ_q [N_STG];
  logic [CW-1:0] integ_d [N_STG];
  logic [DW-1:0] dec_q;
  logic          dump_q;

  for (genvar s = 0; s < int'(N_STG); s++) begin : g_integ
    if (s == 0) begin : g_first
      assign integ_d[s] = integ_q[s] + pdm_ext;
    end else begin : g_next
      assign integ_d[s] = integ_q[s] + integ_d[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < N_STG; s++) begin
        integ_q[s] <= '0;
      end
      dec_q  <= '0;
      dump_q <= 1'b0;
    end else begin
      dump_q <= accept && (dec_q == DW'(R - 1));
      if (accept) begin
        for (int unsigned s = 0; s < N_STG; s++) begin
          integ_q[s] <= integ_d[s];
        end
        dec_q <= dec_q + DW'(1);
      end
    end
  end

  // Combs run once per dump on the held integrator output (M = 1).
  logic [CW-1:0]           comb_v     [N_STG+1];
  logic [CW-1:0]           comb_dly_q [N_STG];
  logic signed [OUT_W-1:0] cic_data_q;
  logic                    cic_valid_q;

  assign comb_v[0] = integ_q[N_STG-1];

  for (genvar s = 0; s < int'(N_STG); s++) begin : g_comb
    assign comb_v[s+1] = comb_v[s] - comb_dly_q[s];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < N_STG; s++) begin
        comb_dly_q[s] <= '0;
      end
      cic_data_q  <= '0;
      cic_valid_q <= 1'b0;
    end else begin
      cic_valid_q <= dump_q;
      if (dump_q) begin
        for (int unsigned s = 0; s < N_STG; s++) begin
          comb_dly_q[s] <= comb_v[s];
        end
        cic_data_q <= comb_v[N_STG][CW-1 -: OUT_W];
      end
    end
  end

  // FIR: tap 0 is the fresh CIC sample, the delay line holds the older ones.
  logic signed [OUT_W-1:0] fir_x_q [FIR_TAPS-1];
  logic signed [OUT_W-1:0] tap_x   [FIR_TAPS];
  logic signed [ACC_W-1:0] prod    [FIR_TAPS];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shr;
  logic signed [OUT_W-1:0] sat_v;
  logic signed [OUT_W-1:0] dout_q;
  logic                    dout_valid_q;

  assign tap_x[0] = cic_data_q;

  for (genvar k = 1; k < int'(FIR_TAPS); k++) begin : g_tap
    assign tap_x[k] = fir_x_q[k-1];
  end

  for (genvar k = 0; k < int'(FIR_TAPS); k++) begin : g_prod
    assign prod[k] = ACC_W'(FIR_H[k]) * ACC_W'(tap_x[k]);
  end

  always_comb begin
    acc = '0;
    for (int unsigned k = 0; k < FIR_TAPS; k++) begin
      acc = acc + prod[k];
    end
  end

  assign shr = acc >>> FIR_SHIFT;

  always_comb begin
    sat_v = shr[OUT_W-1:0];
    if (!(shr[ACC_W-1:OUT_W-1] == '0 || shr[ACC_W-1:OUT_W-1] == '1)) begin
      sat_v = shr[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < FIR_TAPS - 1; k++) begin
        fir_x_q[k] <= '0;
      end
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= cic_valid_q;
      if (cic_valid_q) begin
        for (int unsigned k = 0; k < FIR_TAPS - 1; k++) begin
          fir_x_q[k] <= tap_x[k];
        end
        dout_q <= sat_v;
      end
    end
  end

  assign cic_data   = cic_data_q;
  assign cic_valid  = cic_valid_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_pdm_cic_fir_decimator.sv
// Directed bench for the PDM CIC+FIR decimator, run with a short strobe period.
module tb_pdm_cic_fir_decimator;

  localparam int DIV   = 4;
  localparam int R     = 64;
  localparam int NOUT  = 12;
  localparam int HLEN  = 4 * (R - 1) + 1;
  localparam int HMAX  = 1024;
  localparam int NOVAL = -999999;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic [1:0]         pdm_in = 2'b00;
  logic signed [15:0] cic_data;
  logic               cic_valid;
  logic signed [15:0] dout;
  logic               dout_valid;

  pdm_cic_fir_decimator #(.DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .pdm_in     (pdm_in),
    .cic_data   (cic_data),
    .cic_valid  (cic_valid),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // clocks since the last edge that sampled reset high
  int cyc = 0;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int cic_q[$];
  int dout_q[$];
  int cic_cyc[$];
  int dout_cyc[$];

  always @(negedge clk) begin
    if (cic_valid) begin
      cic_q.push_back(int'(cic_data));
      cic_cyc.push_back(cyc);
    end
    if (dout_valid) begin
      dout_q.push_back(int'(dout));
      dout_cyc.push_back(cyc);
    end
  end

  typedef struct {
    int pat;
    int idx;
    int exp_cic;
    int exp_dout;
    bit chk_cic;
    bit chk_dout;
  } vec_t;

  vec_t   vecs[$];
  int     cap_cic  [3][NOUT];
  int     cap_dout [3][NOUT];
  longint hc  [HLEN];
  int     hist[HMAX];
  int     nhist = 0;
  int     mc  [NOUT];
  int     fh  [7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return NOVAL;
  endfunction

  function automatic int pdm_to_int(input logic [1:0] c);
    if (c == 2'b01) return 1;
    if (c == 2'b11) return -1;
    return 0;
  endfunction

  function automatic logic [1:0] pat_code(input int p, input int n);
    if (p == 0) return 2'b01;
    if (p == 1) return 2'b11;
    return (n % 2 == 0) ? 2'b01 : 2'b11;
  endfunction

  function automatic void add_vec(input int p, input int i, input int ec, input int ed,
                                  input bit cc, input bit cd);
    vec_t v;
    v.pat = p; v.idx = i; v.exp_cic = ec; v.exp_dout = ed;
    v.chk_cic = cc; v.chk_dout = cd;
    vecs.push_back(v);
  endfunction

  // Impulse response of the CIC: four cascaded length-R boxcars.
  task automatic build_hcic();
    longint tmp [HLEN];
    for (int n = 0; n < HLEN; n++) hc[n] = 0;
    hc[0] = 1;
    for (int st = 0; st < 4; st++) begin
      for (int n = 0; n < HLEN; n++) begin
        longint s = 0;
        for (int m = 0; m < R; m++) if (n - m >= 0) s += hc[n - m];
        tmp[n] = s;
      end
      for (int n = 0; n < HLEN; n++) hc[n] = tmp[n];
    end
  endtask

  function automatic int model_cic(input int j);
    longint y = 0;
    for (int k = 0; k < HLEN; k++) begin
      int idx = j * R + R - 1 - k;
      if (idx >= 0 && idx < nhist) y += hc[k] * longint'(hist[idx]);
    end
    return int'(y >>> 10);
  endfunction

  function automatic int model_fir(input int j);
    longint acc = 0;
    longint sh;
    for (int k = 0; k < 7; k++) if (j - k >= 0) acc += longint'(fh[k]) * longint'(mc[j - k]);
    sh = acc >>> 5;
    if (sh > 32767)  sh = 32767;
    if (sh < -32768) sh = -32768;
    return int'(sh);
  endfunction

  task automatic compare_model(input string name);
    for (int j = 0; j < NOUT; j++) mc[j] = model_cic(j);
    for (int j = 0; j < NOUT; j++) begin
      check($sformatf("%s_cic[%0d]", name, j), qget(cic_q, j), mc[j]);
      check($sformatf("%s_dout[%0d]", name, j), qget(dout_q, j), model_fir(j));
    end
  endtask

  // Leaves the bench just after the first edge following reset release.
  task automatic do_reset(input bit chk);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; pdm_in = 2'b00;
    @(posedge clk);
    #1;
    reset = 1'b0;
    if (chk) begin
      check("rst_cic_data", int'(cic_data), 0);
      check("rst_cic_valid", int'(cic_valid), 0);
      check("rst_dout", int'(dout), 0);
      check("rst_dout_valid", int'(dout_valid), 0);
    end
    cic_q.delete(); dout_q.delete(); cic_cyc.delete(); dout_cyc.delete();
    nhist = 0;
    @(posedge clk);
    #1;
  endtask

  // One strobe window: the value is accepted on the last edge of the wait.
  task automatic send(input logic [1:0] code, input logic vld);
    pdm_in = code; in_valid = vld;
    if (vld && nhist < HMAX) begin
      hist[nhist] = pdm_to_int(code);
      nhist++;
    end
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  initial begin
    int pcic[NOUT];
    int pdout[NOUT];
    int ncic[NOUT];
    int ndout[NOUT];
    fh = '{-2, 4, -10, 48, -10, 4, -2};
    pcic  = '{748, 8447, 15763, 16384, 16384, 16384, 16384, 16384, 16384, 16384, 16384, 16384};
    pdout = '{-47, -435, -164, -572, 8534, 17002, 16563, 16802, 16422, 16384, 16384, 16384};
    ncic  = '{-749, -8448, -15764, -16384, -16384, -16384, -16384, -16384, -16384, -16384,
              -16384, -16384};
    ndout = '{46, 434, 163, 570, -8536, -17004, -16563, -16803, -16423, -16384, -16384, -16384};
    for (int i = 0; i < NOUT; i++) begin
      add_vec(0, i, pcic[i], pdout[i], 1'b1, 1'b1);
      add_vec(1, i, ncic[i], ndout[i], 1'b1, 1'b1);
      if (i >= 3) add_vec(2, i, 0, 0, 1'b1, i >= 9);
    end
    build_hcic();

    // constant +1, constant -1, alternating streams
    for (int p = 0; p < 3; p++) begin
      do_reset(p == 0);
      for (int n = 0; n < NOUT * R; n++) send(pat_code(p, n), 1'b1);
      send(2'b00, 1'b0);
      check($sformatf("pat%0d_cic_count", p), cic_q.size(), NOUT);
      check($sformatf("pat%0d_dout_count", p), dout_q.size(), NOUT);
      for (int i = 0; i < NOUT; i++) begin
        cap_cic[p][i]  = qget(cic_q, i);
        cap_dout[p][i] = qget(dout_q, i);
      end
      if (p == 2) compare_model("alt");
    end

    foreach (vecs[v]) begin
      if (vecs[v].chk_cic)
        check($sformatf("vec_p%0d_cic[%0d]", vecs[v].pat, vecs[v].idx),
              cap_cic[vecs[v].pat][vecs[v].idx], vecs[v].exp_cic);
      if (vecs[v].chk_dout)
        check($sformatf("vec_p%0d_dout[%0d]", vecs[v].pat, vecs[v].idx),
              cap_dout[vecs[v].pat][vecs[v].idx], vecs[v].exp_dout);
    end

    // long in_valid=0 gap in the middle of a block holds all state
    do_reset(1'b0);
    for (int n = 0; n < 104; n++) send(2'b01, 1'b1);
    check("pause_pre_count", cic_q.size(), 1);
    pdm_in = 2'b01; in_valid = 1'b0;
    repeat (10 * R * DIV) @(posedge clk);
    #1;
    check("pause_no_cic", cic_q.size(), 1);
    check("pause_no_dout", dout_q.size(), 1);
    check("pause_hold_cic", int'(cic_data), 748);
    check("pause_hold_dout", int'(dout), -47);
    for (int n = 0; n < 24; n++) send(2'b01, 1'b1);
    send(2'b00, 1'b0);
    check("pause_resume_cic", qget(cic_q, 1), 8447);
    check("pause_resume_dout", qget(dout_q, 1), -435);

    // zero stream (both zero codes) stepping to +1 mid-block, against the model
    do_reset(1'b0);
    for (int n = 0; n < 100; n++) send((n % 2 == 0) ? 2'b00 : 2'b10, 1'b1);
    for (int n = 100; n < NOUT * R; n++) send(2'b01, 1'b1);
    send(2'b00, 1'b0);
    compare_model("step");

    // reset in the middle of a decimation discards the partial block
    do_reset(1'b0);
    for (int n = 0; n < 100; n++) send(2'b01, 1'b1);
    check("mid_pre_cic", int'(cic_data), 748);
    do_reset(1'b1);
    for (int n = 0; n < 63; n++) send(2'b01, 1'b1);
    check("mid_no_early_cic", cic_q.size(), 0);
    send(2'b01, 1'b1);
    send(2'b01, 1'b1);
    check("mid_first_cic", qget(cic_q, 0), 748);
    check("mid_first_cic_cyc", qget(cic_cyc, 0), 64 * DIV + 2);
    check("mid_first_dout", qget(dout_q, 0), -47);
    check("mid_first_dout_cyc", qget(dout_cyc, 0), 64 * DIV + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
